// File: rtl/fifo_apb_if.sv
// fifo_apb_if: FIFO read-port plus APB write-bus bundle for fifo_apb_master.
// Signals:
//   rdata, address_out, rempty : FIFO head and empty flag    (slave -> master)
//   rinc                       : FIFO pop strobe             (master -> slave)
//   paddr, pwdata, pwrite      : APB address/data/direction  (master -> slave)
//   psel, penable              : APB phase control           (master -> slave)
//   pready, pslverr            : APB completion and error    (slave -> master)
// Modports: master (fifo_apb_master side), slave (FIFO + APB slave side).
interface fifo_apb_if #(
    parameter int DSIZE  = 32,
    parameter int AWIDTH = 32
);
    logic [DSIZE-1:0]  rdata;
    logic [AWIDTH-1:0] address_out;
    logic              rempty;
    logic              rinc;
    logic [AWIDTH-1:0] paddr;
    logic [DSIZE-1:0]  pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic              pready;
    logic              pslverr;

    modport master (
        input  rdata, address_out, rempty, pready, pslverr,
        output rinc, paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output rdata, address_out, rempty, pready, pslverr,
        input  rinc, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/fifo_apb_master.sv
// fifo_apb_master: pops write-posting FIFO entries and issues each as an APB write.
// Ports:
//   rclk, rrst : read-domain clock and synchronous active-high reset
//   bus        : fifo_apb_if.master (FIFO read port + APB master signals)
//   busy       : high whenever the FSM is not IDLE
//   err_count  : saturating count of errored transfers
//   err_addr   : address of the most recent errored transfer
//   timeout    : one-cycle pulse on a forced completion
// Optional feature: define APB_TIMEOUT_EN to force-complete an ACCESS phase that
// waits TO_CYCLES cycles without pready; otherwise timeout is tied low.
module fifo_apb_master #(
    parameter int DSIZE     = 32,
    parameter int AWIDTH    = 32,
    parameter int ERRW      = 8,
    parameter int TO_CYCLES = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_apb_if.master        bus,
    output logic              busy,
    output logic [ERRW-1:0]   err_count,
    output logic [AWIDTH-1:0] err_addr,
    output logic              timeout
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d, err_addr_q, err_addr_d;
    logic [DSIZE-1:0]  pwdata_q, pwdata_d;
    logic [ERRW-1:0]   err_count_q, err_count_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic              timeout_q, timeout_d;
    logic              to_hit, done, err;

    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to
        $error("fifo_apb_master: TO_CYCLES must be in 2..255");
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] wcnt_q, wcnt_d;

    // Counter holds the number of stalled ACCESS cycles already seen, so the
    // TO_CYCLES-th ACCESS cycle is the one where it equals TO_CYCLES-1.
    assign to_hit = state_q == ACCESS && !bus.pready && wcnt_q == 8'(TO_CYCLES - 1);

    always_comb
        wcnt_d = state_q == SETUP ? 8'd0 :
                 (state_q == ACCESS && !bus.pready) ? wcnt_q + 8'd1 : wcnt_q;

    always_ff @(posedge rclk)
        wcnt_q <= rrst ? 8'd0 : wcnt_d;
`else
    assign to_hit = 1'b0;
`endif

    assign done = state_q == ACCESS && (bus.pready || to_hit);
    // A forced completion happens with pready low, so pslverr is not consulted then.
    assign err  = done && (to_hit || bus.pslverr);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.rempty ? IDLE : FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = !done ? ACCESS : bus.rempty ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        paddr_d     = state_q == LOAD ? bus.address_out : paddr_q;
        pwdata_d    = state_q == LOAD ? bus.rdata : pwdata_q;
        pwrite_d    = state_q == LOAD ? 1'b1 : pwrite_q;
        psel_d      = state_q == LOAD ? 1'b1 : done ? 1'b0 : psel_q;
        penable_d   = state_q == SETUP ? 1'b1 : done ? 1'b0 : penable_q;
        err_count_d = (err && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
        err_addr_d  = err ? paddr_q : err_addr_q;
        timeout_d   = to_hit;
    end

    assign bus.rinc    = state_q == FETCH;
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign busy        = state_q != IDLE;
    assign err_count   = err_count_q;
    assign err_addr    = err_addr_q;
    assign timeout     = timeout_q;
endmodule

// File: doc/fifo_apb_master.md
Name: fifo_apb_master

Overview:
Read-domain consumer of the bridge's async write-posting FIFO. Pops one entry at a time (data word plus address) and issues it as an APB write transfer: SETUP phase, then ACCESS phase until PREADY. Tracks slave errors and exposes simple status. Sits between the FIFO read port (rdata/address_out/rempty/rinc) and the APB slave bus, clocked entirely on rclk.

Parameters:
DSIZE, 32, data width; matches FIFO data width and PWDATA width
AWIDTH, 32, address width; matches FIFO address_out and PADDR width
ERRW, 8, width of the saturating slave-error counter
TO_CYCLES, 16, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined (legal range 2..255)

Ports:
rclk  input  1  read-domain clock; all logic is on its rising edge
rrst  input  1  synchronous, active-high reset
rdata  input  DSIZE  FIFO head data; valid the cycle after a rinc pulse
address_out  input  AWIDTH  FIFO head address; same timing as rdata
rempty  input  1  FIFO empty flag, synchronous to rclk
rinc  output  1  FIFO pop strobe; one cycle per entry
paddr  output  AWIDTH  APB address (registered)
pwdata  output  DSIZE  APB write data (registered)
pwrite  output  1  APB direction; constant 1 outside reset
psel  output  1  APB select (registered)
penable  output  1  APB enable (registered)
pready  input  1  APB slave ready
pslverr  input  1  APB slave error; sampled only on a completing ACCESS cycle
busy  output  1  high whenever state is not IDLE
err_count  output  ERRW  saturating count of errored transfers
err_addr  output  AWIDTH  paddr of the most recent errored transfer
timeout  output  1  one-cycle pulse on forced completion (see Optional Feature)

Behaviour:
- Reset (rrst=1 at a rising edge): state=IDLE; rinc, psel, penable, pwrite, busy and timeout = 0; paddr, pwdata, err_addr = 0; err_count = 0. Reset takes priority over everything. A transfer in flight is abandoned and its entry is lost. This is accepted and is intended only for whole-bridge reset.
- FSM states: IDLE, FETCH, LOAD, SETUP, ACCESS. State is a register. rinc is decoded as (state==FETCH), so it is glitch-free and exactly one cycle wide.
- IDLE: if rempty=0, next state is FETCH; otherwise remain in IDLE.
- FETCH: rinc=1 for this cycle. Next state is LOAD unconditionally.
- LOAD: rdata/address_out are valid (1-cycle FIFO read latency). At the end of this cycle, load pwdata<=rdata and paddr<=address_out, and set psel<=1, penable<=0, pwrite<=1. Next state is SETUP.
- SETUP: psel=1, penable=0. At the end of this cycle, set penable<=1. Next state is ACCESS.
- ACCESS: psel=1, penable=1. paddr and pwdata are held stable.
  - If pready=0, remain in ACCESS.
  - If pready=1, the transfer completes and psel<=0, penable<=0.
  - After completion, if rempty=0, next state is FETCH (back-to-back); otherwise next state is IDLE.
- Latency: rempty falls, then FETCH on the next cycle, and psel rises 2 cycles after FETCH. Minimum spacing is 4 cycles per transfer when pready is tied high.
- Error handling: on a completing ACCESS cycle with pslverr=1, err_count increments, saturating at all-ones and never wrapping, and err_addr<=paddr. pslverr is ignored on every other cycle.
- rempty is only sampled in IDLE and at ACCESS completion. The FIFO cannot go empty between FETCH and LOAD, because this block is the only reader. No pop is ever issued while rempty=1.
- paddr and pwdata retain their last values after completion. They are don't-care while psel=0.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TO_CYCLES-1 with pready still 0, the transfer is force-completed: it is treated as an errored completion (err_count increments and err_addr is updated), and timeout pulses for 1 cycle.
  - The FSM then proceeds as for a normal completion.
  - pready=1 on the same cycle as the limit counts as a normal completion, with no timeout.
- Undefined: no counter is built; the timeout port is tied to 0, and ACCESS waits for pready indefinitely.

Test Plan:
- Single write: FIFO holds one entry {address 0x0000_0010, data 0xDEAD_BEEF}, pready=1 -> one rinc pulse; psel high for exactly 2 cycles; penable high for 1 cycle; paddr=0x10; pwdata=0xDEADBEEF; pwrite=1; busy falls after completion.
- Back-to-back: three entries (0x04/0x11, 0x08/0x22, 0x0C/0x33), pready=1 -> three APB transfers in order, each 4 cycles apart; exactly 3 rinc pulses; returns to IDLE once rempty=1.
- Wait states: pready held low for 5 ACCESS cycles -> psel/penable/paddr/pwdata stable for 6 ACCESS cycles; no rinc during the wait.
- Slave error: two transfers to 0x20 and 0x24, pslverr=1 with pready on the second only -> err_count=1, err_addr=0x24; pslverr pulsed during SETUP has no effect.
- Timeout (macro defined, TO_CYCLES=16): pready held 0 -> forced completion at the 16th ACCESS cycle; timeout=1 for one cycle; err_count+1. With the macro undefined, the same stimulus holds ACCESS indefinitely and timeout stays 0.
- Reset mid-ACCESS: assert rrst for 1 cycle -> next edge gives psel=0, penable=0, rinc=0, err_count=0, state IDLE; a remaining FIFO entry is then fetched normally.
